gyro_spi_reader: RTL and testbench

//  SPI master at the sensor end of the gyro rate path: configures a 3-axis gyro (L3G-style register map),

---
 rtl/gyro_spi_reader.sv | 188 ++++++++++++++++++
 tb/tb_gyro_spi_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gyro_spi_reader.sv
// rtl/gyro_spi_reader.sv - SPI mode-3 master that configures a gyro and periodically reads the X rate
// Output sample is sign/magnitude: bit15 = sign, [7:0] = saturated |raw| >> SHIFT.
module gyro_spi_reader #(
   parameter int         CLK_DIV       = 4,
   parameter int         SAMPLE_PERIOD = 10000,
   parameter logic [7:0] CTRL_REG1_VAL = 8'h0F,
   parameter int         SHIFT         = 2
) (
   input  logic        clk,
   input  logic        RST,
   output logic        spi_sclk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic [15:0] gyroData_x,
   output logic [15:0] raw_x,
   output logic        sample_valid,
   output logic        cfg_done,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_GAP, S_WAIT, S_RD, S_CONV} state_t;

   localparam logic [23:0] CFG_FRAME = {8'h20, CTRL_REG1_VAL, 8'h00};
   localparam logic [23:0] RD_FRAME  = 24'hE8_0000;
   localparam logic [15:0] DIV_MAX   = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_MAX   = 16'(CLK_DIV - 1);
   localparam logic [31:0] PER_MAX   = 32'(SAMPLE_PERIOD - 1);

   state_t      state_q, state_d;
   logic        sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
   logic [23:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] div_q, div_d, gap_q, gap_d;
   logic        half_q, half_d;
   logic [4:0]  bit_q, bit_d;
   logic [31:0] per_q, per_d;
   logic        rd_seen_q, rd_seen_d;
   logic [15:0] gyro_q, gyro_d, raw_q, raw_d;
   logic        valid_q, valid_d, cfg_done_q, cfg_done_d;

   logic        start_cfg, start_rd;
   logic [23:0] frame_w;
   logic [4:0]  last_bit_w;
   logic [15:0] raw_w;
   logic [16:0] mag17_w, m_w;
   logic [7:0]  mag_w;

   // Byte 2 (X_L) arrives first, so it sits in the upper half of rx_q.
   assign raw_w   = {rx_q[7:0], rx_q[15:8]};
   assign mag17_w = raw_w[15] ? (~{raw_w[15], raw_w} + 17'd1) : {1'b0, raw_w};
   assign m_w     = mag17_w >> SHIFT;
   assign mag_w   = (|m_w[16:8]) ? 8'hFF : m_w[7:0];

   assign last_bit_w = (state_q == S_CFG) ? 5'd15 : 5'd23;
   assign frame_w    = start_cfg ? CFG_FRAME : RD_FRAME;

   always_comb begin
      state_d    = state_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      div_d      = div_q;
      half_d     = half_q;
      bit_d      = bit_q;
      gap_d      = (gap_q < GAP_MAX) ? gap_q + 16'd1 : gap_q;
      per_d      = (per_q < PER_MAX) ? per_q + 32'd1 : per_q;
      rd_seen_d  = rd_seen_q;
      gyro_d     = gyro_q;
      raw_d      = raw_q;
      valid_d    = 1'b0;
      cfg_done_d = cfg_done_q;
      start_cfg  = 1'b0;
      start_rd   = 1'b0;

      case (state_q)
         S_IDLE: start_cfg = 1'b1;
         S_CFG, S_RD: begin
            if (div_q != DIV_MAX) begin
               div_d = div_q + 16'd1;
            end else begin
               div_d = 16'd0;
               if (!half_q) begin
                  half_d = 1'b1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[14:0], spi_miso};
               end else if (bit_q == last_bit_w) begin
                  cs_n_d = 1'b1;
                  sclk_d = 1'b1;
                  mosi_d = 1'b0;
                  half_d = 1'b0;
                  bit_d  = 5'd0;
                  gap_d  = 16'd0;
                  if (state_q == S_CFG) begin
                     cfg_done_d = 1'b1;
                     state_d    = S_GAP;
                  end else begin
                     raw_d   = raw_w;
                     gyro_d  = {raw_w[15], 7'b0, mag_w};
                     valid_d = 1'b1;
                     state_d = S_CONV;
                  end
               end else begin
                  bit_d  = bit_q + 5'd1;
                  half_d = 1'b0;
                  sclk_d = 1'b0;
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[22];
               end
            end
         end
         S_CONV: state_d = S_GAP;
         S_GAP, S_WAIT: begin
            // The first read after configuration ignores the sample period.
            if (gap_q >= GAP_MAX && (per_q >= PER_MAX || !rd_seen_q))
               start_rd = 1'b1;
            else if (gap_q >= GAP_MAX)
               state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase

      if (start_cfg || start_rd) begin
         state_d = start_cfg ? S_CFG : S_RD;
         tx_d    = frame_w;
         mosi_d  = frame_w[23];
         cs_n_d  = 1'b0;
         sclk_d  = 1'b0;
         div_d   = 16'd0;
         half_d  = 1'b0;
         bit_d   = 5'd0;
      end
      if (start_rd) begin
         per_d     = 32'd0;
         rd_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         sclk_q     <= 1'b1;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         tx_q       <= 24'd0;
         rx_q       <= 16'd0;
         div_q      <= 16'd0;
         half_q     <= 1'b0;
         bit_q      <= 5'd0;
         gap_q      <= 16'd0;
         per_q      <= 32'd0;
         rd_seen_q  <= 1'b0;
         gyro_q     <= 16'd0;
         raw_q      <= 16'd0;
         valid_q    <= 1'b0;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         div_q      <= div_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         per_q      <= per_d;
         rd_seen_q  <= rd_seen_d;
         gyro_q     <= gyro_d;
         raw_q      <= raw_d;
         valid_q    <= valid_d;
         cfg_done_q <= cfg_done_d;
      end
   end

   assign spi_sclk     = sclk_q;
   assign spi_cs_n     = cs_n_q;
   assign spi_mosi     = mosi_q;
   assign gyroData_x   = gyro_q;
   assign raw_x        = raw_q;
   assign sample_valid = valid_q;
   assign cfg_done     = cfg_done_q;
   assign busy         = ~cs_n_q;

endmodule

// File: tb/tb_gyro_spi_reader.sv
// tb/tb_gyro_spi_reader.sv - directed bench for gyro_spi_reader with SPI slave model and protocol monitor
module tb_gyro_spi_reader;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic        spi_sclk, spi_cs_n, spi_mosi;
   logic        spi_miso = 1'b0;
   logic [15:0] gyroData_x, raw_x;
   logic        sample_valid, cfg_done, busy;

   logic        b_sclk, b_cs_n, b_mosi;
   logic        b_miso = 1'b0;
   logic [15:0] b_gyro, b_raw;
   logic        b_valid, b_cfg_done, b_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gyro_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(1000), .CTRL_REG1_VAL(8'h0F), .SHIFT(2)) dut (
      .clk(clk), .RST(RST), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .gyroData_x(gyroData_x), .raw_x(raw_x), .sample_valid(sample_valid),
      .cfg_done(cfg_done), .busy(busy));

   gyro_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(50), .CTRL_REG1_VAL(8'h0F), .SHIFT(2)) dut_b2b (
      .clk(clk), .RST(RST), .spi_sclk(b_sclk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi),
      .spi_miso(b_miso), .gyroData_x(b_gyro), .raw_x(b_raw), .sample_valid(b_valid),
      .cfg_done(b_cfg_done), .busy(b_busy));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor and slave model for the main instance, all observed mid-cycle.
   int          cyc = 0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_cfg = 1'b0;
   logic [23:0] cap = '0, fr_data = '0;
   int          nbits = 0, lowcnt = 0, fr_bits = 0, fr_low = 0;
   int          viol = 0, nvalid = 0;
   int          falls[$];
   int          rises[$];
   logic [15:0] resp_raw = 16'h0140;
   logic [23:0] resp;

   always @(negedge clk) begin
      cyc++;
      if (prev_cs && !spi_cs_n) begin
         falls.push_back(cyc);
         cap = '0; nbits = 0; lowcnt = 0;
      end
      if (!spi_cs_n) begin
         lowcnt++;
         if (!prev_sclk && spi_sclk) begin
            cap = {cap[22:0], spi_mosi};
            nbits++;
         end
         if (prev_sclk && spi_sclk && spi_mosi !== prev_mosi) viol++;
      end
      if (spi_cs_n && !spi_sclk) viol++;
      if (busy !== ~spi_cs_n) viol++;
      if (RST && cfg_done && !prev_cfg && !(spi_cs_n && !prev_cs)) viol++;
      if (!prev_cs && spi_cs_n) begin
         rises.push_back(cyc);
         fr_data = cap; fr_bits = nbits; fr_low = lowcnt;
      end
      if (sample_valid) nvalid++;
      resp = {8'h00, resp_raw[7:0], resp_raw[15:8]};
      spi_miso = (!spi_cs_n && nbits < 24) ? resp[23 - nbits] : 1'b0;
      prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_mosi = spi_mosi; prev_cfg = cfg_done;
   end

   logic b_prev_cs = 1'b1;
   int   b_last_fall = 0, b_last_rise = 0, b_gap = 0, b_spacing = 0, b_frames = 0;

   always @(negedge clk) begin
      if (b_prev_cs && !b_cs_n) begin
         b_gap = cyc - b_last_rise;
         b_spacing = cyc - b_last_fall;
         b_last_fall = cyc;
         b_frames++;
      end
      if (!b_prev_cs && b_cs_n) b_last_rise = cyc;
      if (b_cs_n && !b_sclk) viol++;
      b_prev_cs = b_cs_n;
   end

   task automatic wait_valid(input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1500 && !ok; i++) begin
         @(negedge clk);
         if (sample_valid) ok = 1'b1;
      end
      if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_cfg(input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (cfg_done) ok = 1'b1;
      end
      if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   logic [15:0] vec_raw [7] = '{16'h0140, 16'hFEC0, 16'h7FFF, 16'h8000, 16'h0000, 16'hFC00, 16'h0400};
   logic [15:0] vec_exp [7] = '{16'h0050, 16'h8050, 16'h00FF, 16'h80FF, 16'h0000, 16'h80FF, 16'h00FF};

   initial begin
      bit ok;
      int nv_before;
      RST = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sclk", 32'(spi_sclk), 32'd1);
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_gyro", 32'(gyroData_x), 32'd0);
      check("rst_raw", 32'(raw_x), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_cfg_done", 32'(cfg_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      resp_raw = vec_raw[0];
      RST = 1'b1;
      wait_cfg("cfg", ok);
      @(negedge clk);
      check("cfg_frame", 32'(fr_data[15:0]), 32'h200F);
      check("cfg_bits", 32'(fr_bits), 32'd16);
      check("cfg_low_cycles", 32'(fr_low), 32'd128);
      check("cfg_done_set", 32'(cfg_done), 32'd1);

      for (int v = 0; v < 7; v++) begin
         wait_valid($sformatf("sample%0d", v), ok);
         if (!ok) break;
         check($sformatf("gyro_%0d", v), 32'(gyroData_x), 32'(vec_exp[v]));
         check($sformatf("raw_%0d", v), 32'(raw_x), 32'(vec_raw[v]));
         @(negedge clk);
         check($sformatf("valid_width_%0d", v), 32'(sample_valid), 32'd0);
         check($sformatf("rd_frame_%0d", v), 32'(fr_data), 32'hE80000);
         check($sformatf("rd_low_%0d", v), 32'(fr_low), 32'd192);
         if (v < 6) resp_raw = vec_raw[v + 1];
         if (v == 0) begin
            repeat (100) @(negedge clk);
            check("hold_gyro", 32'(gyroData_x), 32'h0050);
         end
      end

      check("first_rd_gap", 32'(falls[1] - rises[0]), 32'd4);
      check("period_1", 32'(falls[2] - falls[1]), 32'd1000);
      check("period_2", 32'(falls[3] - falls[2]), 32'd1000);
      check("period_5", 32'(falls[6] - falls[5]), 32'd1000);
      check("nvalid", 32'(nvalid), 32'd7);

      check("b2b_frames_min", 32'(b_frames > 10), 32'd1);
      check("b2b_gap", 32'(b_gap), 32'd4);
      check("b2b_spacing", 32'(b_spacing), 32'd196);

      ok = 1'b0;
      for (int i = 0; i < 1500 && !ok; i++) begin
         @(negedge clk);
         if (!spi_cs_n && nbits == 10 && fr_bits == 24) ok = 1'b1;
      end
      if (!ok) check("midframe_timeout", 32'd0, 32'd1);
      nv_before = nvalid;
      RST = 1'b0;
      @(negedge clk);
      check("abort_cs_n", 32'(spi_cs_n), 32'd1);
      check("abort_sclk", 32'(spi_sclk), 32'd1);
      check("abort_gyro", 32'(gyroData_x), 32'd0);
      check("abort_raw", 32'(raw_x), 32'd0);
      check("abort_valid", 32'(sample_valid), 32'd0);
      check("abort_cfg_done", 32'(cfg_done), 32'd0);
      repeat (2) @(negedge clk);
      RST = 1'b1;
      wait_cfg("recfg", ok);
      @(negedge clk);
      check("recfg_frame", 32'(fr_data[15:0]), 32'h200F);
      check("recfg_bits", 32'(fr_bits), 32'd16);
      check("abort_no_valid", 32'(nvalid), 32'(nv_before));

      check("protocol_violations", 32'(viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
